// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with a valid/ready handshake.
//
// A 2-entry skid buffer (output slot + skid slot) lets in_ready come
// straight from a register while still passing one transfer per cycle.
// Also handles flush, NOP bubble insertion and a sideband (PC-style)
// field that a bubble loads from in_info instead of clearing.
//
// Ports:
//   clk, cpurst_n           clock, synchronous active-low reset
//   in_valid/in_ready       upstream handshake; in_ctrl/in_info payload
//   out_valid/out_ready     downstream handshake; out_ctrl/out_info payload
//   flush                   drop every held entry
//   bubble/bubble_done      NOP insertion request / acknowledge
//   skid_full               skid slot occupied (debug)
//
// Optional macro EX_MEM_STAGE_PERF_EN adds saturating performance
// counters (stall, bubble, flush) with a synchronous clear (perf_clr).
module ex_mem_stage #(
   parameter int unsigned CTRL_W = 128,
   parameter int unsigned INFO_W = 32
`ifdef EX_MEM_STAGE_PERF_EN
   ,parameter int unsigned CNT_W = 32
`endif
) (
   input  logic              clk,
   input  logic              cpurst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [INFO_W-1:0] in_info,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [INFO_W-1:0] out_info,
   input  logic              flush,
   input  logic              bubble,
   output logic              bubble_done,
   output logic              skid_full
`ifdef EX_MEM_STAGE_PERF_EN
   ,input  logic             perf_clr
   ,output logic [CNT_W-1:0] perf_stall_cnt
   ,output logic [CNT_W-1:0] perf_bubble_cnt
   ,output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

   logic              out_vld_q, out_vld_d;
   logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
   logic [INFO_W-1:0] out_info_q, out_info_d;
   logic              skid_vld_q, skid_vld_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [INFO_W-1:0] skid_info_q, skid_info_d;

   logic out_free;
   logic acc;

   // in_ready depends only on registered state and the bubble request.
   assign in_ready    = ~skid_vld_q & ~bubble;
   assign out_free    = ~out_vld_q | out_ready;
   assign acc         = in_valid & in_ready;
   assign bubble_done = bubble & ~flush & out_free & ~skid_vld_q;

   always_comb begin
      out_vld_d   = out_vld_q;
      out_ctrl_d  = out_ctrl_q;
      out_info_d  = out_info_q;
      skid_vld_d  = skid_vld_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_info_d = skid_info_q;
      if (flush) begin
         // Sideband is kept so the PC of the flushed slot stays visible.
         out_vld_d   = 1'b0;
         out_ctrl_d  = '0;
         skid_vld_d  = 1'b0;
         skid_ctrl_d = '0;
      end else if (bubble_done) begin
         // in_ready is 0 here, so the upstream entry stays pending.
         out_vld_d  = 1'b1;
         out_ctrl_d = '0;
         out_info_d = in_info;
      end else if (skid_vld_q && out_ready) begin
         out_vld_d  = 1'b1;
         out_ctrl_d = skid_ctrl_q;
         out_info_d = skid_info_q;
         skid_vld_d = 1'b0;
      end else if (acc && out_free) begin
         out_vld_d  = 1'b1;
         out_ctrl_d = in_ctrl;
         out_info_d = in_info;
      end else if (acc) begin
         skid_vld_d  = 1'b1;
         skid_ctrl_d = in_ctrl;
         skid_info_d = in_info;
      end else if (out_ready) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!cpurst_n) begin
         out_vld_q   <= 1'b0;
         out_ctrl_q  <= '0;
         out_info_q  <= '0;
         skid_vld_q  <= 1'b0;
         skid_ctrl_q <= '0;
         skid_info_q <= '0;
      end else begin
         out_vld_q   <= out_vld_d;
         out_ctrl_q  <= out_ctrl_d;
         out_info_q  <= out_info_d;
         skid_vld_q  <= skid_vld_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_info_q <= skid_info_d;
      end
   end

   assign out_valid = out_vld_q;
   assign out_ctrl  = out_ctrl_q;
   assign out_info  = out_info_q;
   assign skid_full = skid_vld_q;

`ifdef EX_MEM_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;
   logic             stall_inc, bubble_inc, flush_inc;

   assign stall_inc  = out_vld_q & ~out_ready;
   assign bubble_inc = bubble_done;
   // Only count flushes that actually discard something.
   assign flush_inc  = flush & (out_vld_q | skid_vld_q);

   always_ff @(posedge clk) begin
      if (!cpurst_n || perf_clr) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         if (stall_inc && (stall_cnt_q != '1))   stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
         if (bubble_inc && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
         if (flush_inc && (flush_cnt_q != '1))   flush_cnt_q  <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign perf_stall_cnt  = stall_cnt_q;
   assign perf_bubble_cnt = bubble_cnt_q;
   assign perf_flush_cnt  = flush_cnt_q;
`else
   // No performance counters in this build.
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed, table-driven bench for ex_mem_stage. Each vector drives inputs
// after the falling edge, checks in_ready/bubble_done before the rising
// edge, then checks the registered outputs just after it.
module tb_ex_mem_stage;

   localparam int unsigned CW = 16;
   localparam int unsigned IW = 32;

   logic          clk = 1'b0;
   logic          cpurst_n;
   logic          in_valid, in_ready;
   logic [CW-1:0] in_ctrl;
   logic [IW-1:0] in_info;
   logic          out_valid, out_ready;
   logic [CW-1:0] out_ctrl;
   logic [IW-1:0] out_info;
   logic          flush, bubble, bubble_done, skid_full;
`ifdef EX_MEM_STAGE_PERF_EN
   logic          perf_clr;
   logic [3:0]    perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(
      .CTRL_W(CW),
      .INFO_W(IW)
`ifdef EX_MEM_STAGE_PERF_EN
      ,.CNT_W(4)
`endif
   ) dut (
      .clk        (clk),
      .cpurst_n   (cpurst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ctrl    (in_ctrl),
      .in_info    (in_info),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ctrl   (out_ctrl),
      .out_info   (out_info),
      .flush      (flush),
      .bubble     (bubble),
      .bubble_done(bubble_done),
      .skid_full  (skid_full)
`ifdef EX_MEM_STAGE_PERF_EN
      ,.perf_clr       (perf_clr)
      ,.perf_stall_cnt (perf_stall_cnt)
      ,.perf_bubble_cnt(perf_bubble_cnt)
      ,.perf_flush_cnt (perf_flush_cnt)
`endif
   );

   typedef struct {
      logic          rst_n;
      logic          iv;
      logic [CW-1:0] ic;
      logic [IW-1:0] ii;
      logic          ordy;
      logic          fl;
      logic          bb;
      logic          e_irdy;
      logic          e_bd;
      logic          e_ov;
      logic [CW-1:0] e_oc;
      logic [IW-1:0] e_oi;
      logic          e_sk;
   } vec_t;

   localparam int NV = 27;
   vec_t vecs [NV];

   function automatic vec_t mk(logic r, logic iv, logic [CW-1:0] ic, logic [IW-1:0] ii,
                               logic ordy, logic fl, logic bb, logic e_irdy, logic e_bd,
                               logic e_ov, logic [CW-1:0] e_oc, logic [IW-1:0] e_oi,
                               logic e_sk);
      vec_t v;
      v.rst_n = r;  v.iv = iv; v.ic = ic; v.ii = ii; v.ordy = ordy; v.fl = fl; v.bb = bb;
      v.e_irdy = e_irdy; v.e_bd = e_bd; v.e_ov = e_ov; v.e_oc = e_oc; v.e_oi = e_oi;
      v.e_sk = e_sk;
      return v;
   endfunction

   task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (vec %0d): got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(logic r, logic iv, logic [CW-1:0] ic, logic [IW-1:0] ii,
                        logic ordy, logic fl, logic bb);
      @(negedge clk);
      cpurst_n = r; in_valid = iv; in_ctrl = ic; in_info = ii;
      out_ready = ordy; flush = fl; bubble = bb;
   endtask

   task automatic chk_regs(int idx, logic ov, logic [CW-1:0] oc, logic [IW-1:0] oi,
                           logic sk);
      chk("out_valid", idx, 32'(out_valid), 32'(ov));
      chk("out_ctrl",  idx, 32'(out_ctrl),  32'(oc));
      chk("out_info",  idx, out_info,       oi);
      chk("skid_full", idx, 32'(skid_full), 32'(sk));
   endtask

   initial begin
      // Stream 1..4 at full rate.
      vecs[0]  = mk(1, 1, 1,     'h101,      1, 0, 0, 1, 0, 1, 1,     'h101,      0);
      vecs[1]  = mk(1, 1, 2,     'h102,      1, 0, 0, 1, 0, 1, 2,     'h102,      0);
      vecs[2]  = mk(1, 1, 3,     'h103,      1, 0, 0, 1, 0, 1, 3,     'h103,      0);
      vecs[3]  = mk(1, 1, 4,     'h104,      1, 0, 0, 1, 0, 1, 4,     'h104,      0);
      vecs[4]  = mk(1, 0, 0,     0,          1, 0, 0, 1, 0, 0, 4,     'h104,      0);
      // Stall with 11 landing in the skid slot, then release.
      vecs[5]  = mk(1, 1, 10,    'h110,      1, 0, 0, 1, 0, 1, 10,    'h110,      0);
      vecs[6]  = mk(1, 1, 11,    'h111,      0, 0, 0, 1, 0, 1, 10,    'h110,      1);
      vecs[7]  = mk(1, 1, 12,    'h112,      0, 0, 0, 0, 0, 1, 10,    'h110,      1);
      vecs[8]  = mk(1, 1, 12,    'h112,      0, 0, 0, 0, 0, 1, 10,    'h110,      1);
      vecs[9]  = mk(1, 1, 12,    'h112,      0, 0, 0, 0, 0, 1, 10,    'h110,      1);
      vecs[10] = mk(1, 1, 12,    'h112,      1, 0, 0, 0, 0, 1, 11,    'h111,      0);
      vecs[11] = mk(1, 1, 12,    'h112,      1, 0, 0, 1, 0, 1, 12,    'h112,      0);
      vecs[12] = mk(1, 0, 0,     0,          1, 0, 0, 1, 0, 0, 12,    'h112,      0);
      // Bubble while the output drains.
      vecs[13] = mk(1, 1, 20,    'h120,      1, 0, 0, 1, 0, 1, 20,    'h120,      0);
      vecs[14] = mk(1, 1, 21,    'h80000040, 1, 0, 1, 0, 1, 1, 0,     'h80000040, 0);
      vecs[15] = mk(1, 1, 21,    'h121,      1, 0, 0, 1, 0, 1, 21,    'h121,      0);
      // Flush beats bubble with the skid full.
      vecs[16] = mk(1, 1, 30,    'h130,      0, 0, 0, 1, 0, 1, 21,    'h121,      1);
      vecs[17] = mk(1, 1, 31,    'h131,      0, 1, 1, 0, 0, 0, 0,     'h121,      0);
      // Reset with both slots full, then resume.
      vecs[18] = mk(1, 1, 40,    'h140,      0, 0, 0, 1, 0, 1, 40,    'h140,      0);
      vecs[19] = mk(1, 1, 41,    'h141,      0, 0, 0, 1, 0, 1, 40,    'h140,      1);
      vecs[20] = mk(0, 1, 42,    'h142,      0, 0, 0, 0, 0, 0, 0,     0,          0);
      vecs[21] = mk(1, 1, 5,     'h105,      1, 0, 0, 1, 0, 1, 5,     'h105,      0);
      vecs[22] = mk(1, 1, 6,     'h106,      1, 0, 0, 1, 0, 1, 6,     'h106,      0);
      vecs[23] = mk(1, 0, 0,     0,          1, 0, 0, 1, 0, 0, 6,     'h106,      0);
      // Bubble held while output blocked, completes when it frees.
      vecs[24] = mk(1, 1, 'h50,  'h150,      0, 0, 0, 1, 0, 1, 'h50,  'h150,      0);
      vecs[25] = mk(1, 1, 'h51,  'h151,      0, 0, 1, 0, 0, 1, 'h50,  'h150,      0);
      vecs[26] = mk(1, 1, 'h51,  'h1ff,      1, 0, 1, 0, 1, 1, 0,     'h1ff,      0);

`ifdef EX_MEM_STAGE_PERF_EN
      perf_clr = 1'b0;
`endif
      // Initial reset.
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk_regs(-1, 0, 0, 0, 0);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst_n, vecs[i].iv, vecs[i].ic, vecs[i].ii, vecs[i].ordy,
               vecs[i].fl, vecs[i].bb);
         #1;
         chk("in_ready",    i, 32'(in_ready),    32'(vecs[i].e_irdy));
         chk("bubble_done", i, 32'(bubble_done), 32'(vecs[i].e_bd));
         @(posedge clk); #1;
         chk_regs(i, vecs[i].e_ov, vecs[i].e_oc, vecs[i].e_oi, vecs[i].e_sk);
      end

`ifdef EX_MEM_STAGE_PERF_EN
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("perf_stall_rst",  100, 32'(perf_stall_cnt),  0);
      chk("perf_bubble_rst", 100, 32'(perf_bubble_cnt), 0);
      chk("perf_flush_rst",  100, 32'(perf_flush_cnt),  0);
      drive(1, 1, 7, 'h107, 0, 0, 0);
      for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("perf_stall_sat", 101, 32'(perf_stall_cnt), 15);
      drive(1, 0, 0, 0, 0, 0, 0);
      perf_clr = 1'b1;
      @(posedge clk); #1;
      chk("perf_stall_clr", 102, 32'(perf_stall_cnt), 0);
      drive(1, 0, 0, 0, 0, 1, 0);
      perf_clr = 1'b0;
      @(posedge clk); #1;
      chk("perf_flush_cnt", 103, 32'(perf_flush_cnt), 1);
      drive(1, 0, 0, 'h2a, 0, 0, 1);
      @(posedge clk); #1;
      chk("perf_bubble_cnt", 104, 32'(perf_bubble_cnt), 1);
      chk("perf_flush_hold", 104, 32'(perf_flush_cnt),  1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
